irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_ctrl_if.sv | 35 +++
 rtl/irq_sync.sv | 42 ++++
 rtl/irq_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and vector-table constants for irq_ctrl.
package irq_pkg;

    // Request/service sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ENTRY   = 2'd2,
        ST_SERVICE = 2'd3
    } irq_state_e;

    // Default ISR vector table base address.
    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_1C00;

    // Byte distance between consecutive vector table entries.
    localparam logic [31:0] VEC_STRIDE = 32'd4;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: request/acknowledge handshake between irq_ctrl and the control unit.
// master = interrupt controller side, slave = control unit side.
interface irq_ctrl_if #(
    parameter int NUM_IRQ = 16
);
    localparam int IDW = $clog2(NUM_IRQ);

    logic           irq_status_update;
    logic           irq_context;
    logic           irq_ack;
    logic           irq;
    logic           irq_status;
    logic [IDW-1:0] irq_id;
    logic [31:0]    irq_addr;

    modport master (
        input  irq_status_update,
        input  irq_context,
        input  irq_ack,
        output irq,
        output irq_status,
        output irq_id,
        output irq_addr
    );

    modport slave (
        output irq_status_update,
        output irq_context,
        output irq_ack,
        input  irq,
        input  irq_status,
        input  irq_id,
        input  irq_addr
    );
endinterface

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchronizer for one raw interrupt line, producing the
// per-cycle "set pending" request. With IRQ_CTRL_EDGE_DETECT_EN defined the
// request fires only on a synchronized 0->1 transition; otherwise it follows
// the synchronized level.
module irq_sync (
    input  logic CLK,
    input  logic RES_N,
    input  logic irq_i,
    output logic set_o
);
    logic sync1_q;
    logic sync2_q;

    // Metastability chain for the asynchronous line.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef IRQ_CTRL_EDGE_DETECT_EN
    logic hist_q;

    // Previous synchronized value, used to spot rising edges.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync2_q;
        end
    end

    assign set_o = sync2_q & ~hist_q;
`else
    assign set_o = sync2_q;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller. Raw lines are synchronized,
// latched into sticky pending bits, and the lowest pending index is offered
// to the control unit one at a time (no preemption).
// Optional feature macro: IRQ_CTRL_EDGE_DETECT_EN (edge-triggered pending set).
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no request outstanding; pick lowest pending index
//   ST_REQ     | irq asserted, waiting for ISR entry (update, context=1)
//   ST_ENTRY   | ISR entered, waiting for ack to retire the pending bit
//   ST_SERVICE | ISR running, waiting for MRET (update, context=0)
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ  = 16,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic               CLK,
    input  logic               RES_N,
    input  logic [NUM_IRQ-1:0] irq_in,
    irq_ctrl_if.master         bus
);
    localparam int IDW = $clog2(NUM_IRQ);

    irq_state_e         state_q;
    logic               irq_q;
    logic               irq_status_q;
    logic [IDW-1:0]     irq_id_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] set_v;
    logic [NUM_IRQ-1:0] clr_v;
    logic [IDW-1:0]     first_idx;
    logic               ack_take;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        irq_sync u_sync (
            .CLK   (CLK),
            .RES_N (RES_N),
            .irq_i (irq_in[gi]),
            .set_o (set_v[gi])
        );
    end

    // Lowest set pending index wins (bit 0 is highest priority).
    always_comb begin
        first_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = IDW'(i);
            end
        end
    end

    assign ack_take = (state_q == ST_ENTRY) && bus.irq_ack;

    // Pending update; a set landing on a bit being cleared keeps it set.
    always_comb begin
        clr_v = '0;
        if (ack_take) begin
            clr_v[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    // Sticky pending register.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Request/service sequencer with registered handshake outputs.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            irq_status_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        irq_id_q <= first_idx;
                        irq_q    <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.irq_status_update && bus.irq_context) begin
                        irq_status_q <= 1'b1;
                        irq_q        <= 1'b0;
                        state_q      <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (ack_take) begin
                        state_q <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.irq_status_update && !bus.irq_context) begin
                        irq_status_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_status = irq_status_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.irq_addr   = VEC_BASE + (32'(irq_id_q) * VEC_STRIDE);

endmodule
